load_writeback_unit: RTL and testbench
======================================

Name: load_writeback_unit

Overview:
Multi-cycle load sequencer sitting between the register file, data memory and write-back port. It takes a base register value and a 16-bit immediate, and forms the effective address (base + sign-extended imm). It then issues a handshaked memory read, extracts the byte, half or word, and sign- or zero-extends it. Finally it drives a single-cycle register-file write of the result.

Parameters:
DATA_WIDTH, 32, width of base, address, memory data and write data
IMM_WIDTH, 16, width of the immediate field
MAX_WAIT, 15, cycles mem_read may stay high without mem_ready before timeout (minimum 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request a load; sampled only in IDLE
base_data  input  DATA_WIDTH  base register value (reg_data1)
imm  input  IMM_WIDTH  signed offset
load_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
load_unsigned  input  1  1 = zero-extend, 0 = sign-extend
dest_reg  input  5  destination register index
mem_read  output  1  memory read request
mem_addr  output  DATA_WIDTH  effective address
mem_rdata  input  DATA_WIDTH  memory read data, valid when mem_ready=1
mem_ready  input  1  memory completion strobe
reg_write  output  1  register-file write enable, one-cycle pulse
write_reg  output  5  register-file write index
write_data  output  DATA_WIDTH  extended load result
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, concurrent with the WB state
timeout  output  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; wait counter 0; captured operands 0. Reset mid-operation aborts without a register write.
- All outputs are registered. The state machine is IDLE -> ADDR -> MEM -> WB -> IDLE.
- IDLE: if start=1 at an edge, capture base_data, imm, load_size, load_unsigned and dest_reg, then go to ADDR. start is ignored in every other state.
- ADDR: mem_addr <= base + sext(imm), modulo 2^DATA_WIDTH (wraps, no overflow flag). Then mem_read <= 1, wait counter <= 0, go to MEM.
- MEM, mem_ready=1 at an edge: capture mem_rdata, mem_read <= 0, go to WB. write_data and write_reg are loaded at this same edge.
- MEM, mem_ready=0: increment the wait counter. When the counter reaches MAX_WAIT: mem_read <= 0, timeout pulses for one cycle, go to IDLE, no write.
- WB (one cycle): reg_write=1 unless write_reg==0 (r0 is never written); done=1. Next edge goes to IDLE, and reg_write and done return to 0.
- Latency with zero-wait memory: start sampled at edge E; mem_read high from E+1 to E+2; reg_write high from E+2 to E+3. Each cycle without mem_ready adds one cycle.
- Extraction is little-endian:
  - byte: lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - half: addr[1] selects [15:0] or [31:16].
  - word: full word.
  - Extension uses load_unsigned.
- mem_addr holds its value after the access; write_data holds until the next WB.

Optional Feature:
LOAD_MISALIGN_TRAP_EN.
- Defined: in ADDR, a half access with addr[0]=1 or a word access with addr[1:0]!=0 skips memory entirely. mem_read stays 0, a one-cycle `misaligned` output pulse is produced, the block returns to IDLE, and there is no write. The `misaligned` port exists only when the macro is defined.
- Undefined: low address bits are ignored as described in Behaviour (half uses addr[1] only, word ignores addr[1:0]).

Decomposition:
- Package load_pkg holds:
  - state enum (IDLE, ADDR, MEM, WB);
  - size encodings LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10;
  - function sext16to32.
- One combinational sub-module, load_extract, does lane selection plus sign/zero extension. Inputs: rdata, addr[1:0], size, unsigned. Output: ext_data.

Test Plan:
1. base=100, imm=16'hFFFC, word, dest=5, mem_rdata=32'hDEADBEEF, ready on the first MEM cycle -> mem_addr=96; reg_write pulses 2 cycles after start with write_reg=5, write_data=32'hDEADBEEF; done high in the same cycle.
2. Byte at addr 0x67 (lane 3), rdata=32'h80112233: signed -> 32'hFFFFFF80; unsigned -> 32'h00000080.
3. Half at addr 0x102, rdata=32'h9ABC1234, signed -> 32'hFFFF9ABC. mem_ready delayed 3 cycles -> mem_read high for 4 cycles; reg_write arrives 3 cycles later than in test 1.
4. mem_ready never asserted -> mem_read drops after MAX_WAIT=15 cycles, timeout pulses once, no reg_write, busy falls. A second start pulse while busy is ignored.
5. dest_reg=0 -> done pulses, reg_write stays 0. base=32'hFFFFFFFE, imm=4 -> mem_addr=2 (wrap).
6. reset driven low while in MEM -> all outputs 0 immediately (async) and no write. With LOAD_MISALIGN_TRAP_EN defined, a word load at addr 0x101 -> misaligned pulse, mem_read never asserted.

Source files
------------

// File: rtl/load_pkg.sv
// Shared types and helpers for the load write-back unit: FSM states, load-size
// encodings and the 16-to-32 sign extension used by the lane extractor.
package load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  function automatic logic [31:0] sext16to32(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane selection plus sign/zero extension of a 32-bit memory word.
module load_extract
  import load_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data
);

  logic [7:0]  lane_byte_s;
  logic [15:0] lane_half_s;

  // Pick the addressed byte/half, then extend to the full word
  always_comb begin
    lane_byte_s = 8'h00;
    lane_half_s = 16'h0000;
    ext_data    = 32'h0000_0000;

    case (addr)
      2'b00:   lane_byte_s = rdata[7:0];
      2'b01:   lane_byte_s = rdata[15:8];
      2'b10:   lane_byte_s = rdata[23:16];
      2'b11:   lane_byte_s = rdata[31:24];
      default: lane_byte_s = 8'h00;
    endcase

    if (addr[1]) begin
      lane_half_s = rdata[31:16];
    end else begin
      lane_half_s = rdata[15:0];
    end

    // Size 2'b11 falls into the word path
    case (size)
      LS_BYTE: begin
        if (is_unsigned) begin
          ext_data = {24'h00_0000, lane_byte_s};
        end else begin
          ext_data = {{24{lane_byte_s[7]}}, lane_byte_s};
        end
      end
      LS_HALF: begin
        if (is_unsigned) begin
          ext_data = {16'h0000, lane_half_s};
        end else begin
          ext_data = sext16to32(lane_half_s);
        end
      end
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// Multi-cycle load sequencer: address generation, handshaked memory read, extraction, write-back.
// Optional macro LOAD_MISALIGN_TRAP_EN adds the misaligned-access trap and its output port.
module load_writeback_unit
  import load_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base_data,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [4:0]            dest_reg,
  output logic                  mem_read,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  reg_write,
  output logic [4:0]            write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
`ifdef LOAD_MISALIGN_TRAP_EN
  ,
  output logic                  misaligned
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  state_t                state_r;
  logic [DATA_WIDTH-1:0] base_r;
  logic [IMM_WIDTH-1:0]  imm_r;
  logic [1:0]            size_r;
  logic                  unsigned_r;
  logic [4:0]            dest_r;
  logic [CW-1:0]         wait_cnt_r;

  logic [DATA_WIDTH-1:0] addr_s;
  logic [CW-1:0]         cnt_next_s;
  logic [31:0]           ext_s;

  assign addr_s     = base_r + {{(DATA_WIDTH-IMM_WIDTH){imm_r[IMM_WIDTH-1]}}, imm_r};
  assign cnt_next_s = wait_cnt_r + CW'(1);

  load_extract u_extract (
    .rdata       (mem_rdata),
    .addr        (mem_addr[1:0]),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .ext_data    (ext_s)
  );

`ifdef LOAD_MISALIGN_TRAP_EN
  logic misalign_s;

  // Half needs addr[0]==0, word needs addr[1:0]==0
  always_comb begin
    misalign_s = 1'b0;
    case (size_r)
      LS_BYTE: misalign_s = 1'b0;
      LS_HALF: misalign_s = addr_s[0];
      default: misalign_s = |addr_s[1:0];
    endcase
  end
`endif

  // Load sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      base_r     <= '0;
      imm_r      <= '0;
      size_r     <= 2'b00;
      unsigned_r <= 1'b0;
      dest_r     <= 5'd0;
      wait_cnt_r <= '0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      reg_write  <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          reg_write <= 1'b0;
          done      <= 1'b0;
          timeout   <= 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
          misaligned <= 1'b0;
`endif
          if (start) begin
            base_r     <= base_data;
            imm_r      <= imm;
            size_r     <= load_size;
            unsigned_r <= load_unsigned;
            dest_r     <= dest_reg;
            busy       <= 1'b1;
            state_r    <= ADDR;
          end else begin
            state_r    <= IDLE;
          end
        end
        ADDR: begin
          mem_addr   <= addr_s;
          wait_cnt_r <= '0;
`ifdef LOAD_MISALIGN_TRAP_EN
          if (misalign_s) begin
            misaligned <= 1'b1;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end else begin
            mem_read   <= 1'b1;
            state_r    <= MEM;
          end
`else
          mem_read <= 1'b1;
          state_r  <= MEM;
`endif
        end
        MEM: begin
          if (mem_ready) begin
            mem_read   <= 1'b0;
            write_data <= ext_s;
            write_reg  <= dest_r;
            reg_write  <= (dest_r != 5'd0);
            done       <= 1'b1;
            state_r    <= WB;
          end else if (cnt_next_s == WAIT_LIMIT) begin
            wait_cnt_r <= cnt_next_s;
            mem_read   <= 1'b0;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end else begin
            wait_cnt_r <= cnt_next_s;
          end
        end
        WB: begin
          reg_write <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          reg_write <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed scoreboard bench for load_writeback_unit (honours LOAD_MISALIGN_TRAP_EN).
module tb_load_writeback_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_data;
  logic [15:0] imm;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic [4:0]  dest_reg;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        timeout;
`ifdef LOAD_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  load_writeback_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_data     (base_data),
    .imm           (imm),
    .load_size     (load_size),
    .load_unsigned (load_unsigned),
    .dest_reg      (dest_reg),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout)
`ifdef LOAD_MISALIGN_TRAP_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete load; expected write-back is queued before stimulus is applied
  task automatic run_load(input logic [31:0] b, input logic [15:0] im, input logic [1:0] sz,
                          input logic uns, input logic [4:0] dst, input logic [31:0] rd,
                          input int delay, input logic [31:0] exp_addr, input logic [31:0] exp_data);
    exp_t e;
    sb.push_back('{we: (dst != 5'd0), idx: dst, data: exp_data});
    @(negedge clk);
    base_data = b; imm = im; load_size = sz; load_unsigned = uns; dest_reg = dst; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("mem_read_in_addr", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    check("mem_read_on", {31'd0, mem_read}, 32'd1);
    check("mem_addr", mem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("mem_read_wait", {31'd0, mem_read}, 32'd1);
      check("no_early_done", {31'd0, done}, 32'd0);
    end
    mem_ready = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("mem_read_off", {31'd0, mem_read}, 32'd0);
    if (sb.size() == 0) begin
      checks++; fails++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("reg_write", {31'd0, reg_write}, {31'd0, e.we});
      check("write_reg", {27'd0, write_reg}, {27'd0, e.idx});
      check("write_data", write_data, e.data);
      @(negedge clk);
      check("done_clear", {31'd0, done}, 32'd0);
      check("reg_write_clear", {31'd0, reg_write}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("write_data_hold", write_data, e.data);
      check("mem_addr_hold", mem_addr, exp_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi_cnt;
    int to_cnt;
    int rw_cnt;
    int dn_cnt;
    reset = 1'b0; start = 1'b0; base_data = 32'h0; imm = 16'h0; load_size = 2'b00;
    load_unsigned = 1'b0; dest_reg = 5'd0; mem_rdata = 32'h0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
`ifdef LOAD_MISALIGN_TRAP_EN
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
`endif
    reset = 1'b1;

    run_load(32'd100, 16'hFFFC, 2'b10, 1'b0, 5'd5, 32'hDEADBEEF, 0, 32'd96, 32'hDEADBEEF);
    run_load(32'h60, 16'h0007, 2'b00, 1'b0, 5'd3, 32'h80112233, 0, 32'h67, 32'hFFFFFF80);
    run_load(32'h60, 16'h0007, 2'b00, 1'b1, 5'd4, 32'h80112233, 0, 32'h67, 32'h00000080);
    run_load(32'h100, 16'h0002, 2'b01, 1'b0, 5'd6, 32'h9ABC1234, 3, 32'h102, 32'hFFFF9ABC);
    run_load(32'h400, 16'h0001, 2'b00, 1'b1, 5'd8, 32'h12345678, 1, 32'h401, 32'h00000056);
    run_load(32'h10, 16'hFFF8, 2'b11, 1'b0, 5'd31, 32'hCAFEF00D, 0, 32'h8, 32'hCAFEF00D);
    run_load(32'h20, 16'h0000, 2'b01, 1'b1, 5'd2, 32'h00008001, 0, 32'h20, 32'h00008001);
    run_load(32'hFFFFFFFE, 16'h0004, 2'b01, 1'b0, 5'd0, 32'h7FFF0001, 0, 32'h2, 32'h00007FFF);

    // Timeout: memory never answers; a second start mid-wait must be ignored
    @(negedge clk);
    base_data = 32'h200; imm = 16'h0; load_size = 2'b10; dest_reg = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi_cnt = 0; to_cnt = 0; rw_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin
        dest_reg = 5'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (mem_read) hi_cnt++;
      if (timeout) to_cnt++;
      if (reg_write) rw_cnt++;
      if (done) dn_cnt++;
    end
    start = 1'b0;
    check("timeout_read_cycles", hi_cnt, 32'd15);
    check("timeout_pulses", to_cnt, 32'd1);
    check("timeout_no_write", rw_cnt, 32'd0);
    check("timeout_no_done", dn_cnt, 32'd0);
    check("timeout_busy_low", {31'd0, busy}, 32'd0);

    // Asynchronous reset while waiting in MEM
    @(negedge clk);
    base_data = 32'h300; imm = 16'h0; load_size = 2'b10; dest_reg = 5'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_mem_read", {31'd0, mem_read}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_mem_read", {31'd0, mem_read}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_mem_addr", mem_addr, 32'd0);
    check("async_write_data", write_data, 32'd0);
    check("async_write_reg", {27'd0, write_reg}, 32'd0);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
    rw_cnt = 0; hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (reg_write) rw_cnt++;
      if (busy) hi_cnt++;
    end
    mem_ready = 1'b0;
    check("post_reset_no_write", rw_cnt, 32'd0);
    check("post_reset_idle", hi_cnt, 32'd0);

`ifdef LOAD_MISALIGN_TRAP_EN
    @(negedge clk);
    base_data = 32'h100; imm = 16'h0001; load_size = 2'b10; dest_reg = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to_cnt = 0; hi_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (misaligned) to_cnt++;
      if (mem_read) hi_cnt++;
      if (reg_write) rw_cnt++;
    end
    check("misaligned_pulses", to_cnt, 32'd1);
    check("misaligned_no_read", hi_cnt, 32'd0);
    check("misaligned_no_write", rw_cnt, 32'd0);
    check("misaligned_busy_low", {31'd0, busy}, 32'd0);
`endif

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
